// File: rtl/econet_rx_frame.sv
// econet_rx_frame: Econet frame receiver sitting behind the RX PHY.
// Filters on destination station/network, checks the HDLC FCS
// (CRC-16/CCITT, reflected) and holds one accepted frame in a local
// byte buffer that the host reads at random and releases with frame_ack.
//
// Host handshake: frame_ready is the valid, frame_ack is the ready.
// The buffer is handed over on any edge where both are high; frame_ready
// drops on that edge and frame_ack is ignored while frame_ready is low.
module econet_rx_frame #(
    parameter int ADDR_W = 8
) (
    input  logic              econet_clk,
    input  logic              reset,
    input  logic [7:0]        data_in,
    input  logic              data_strobe,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic [7:0]        station_id,
    input  logic [7:0]        net_id,
    input  logic              promisc,
    output logic              frame_ready,
    output logic [ADDR_W:0]   frame_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              frame_ack,
    output logic              err_strobe,
    output logic [1:0]        err_code,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MIN_CNT  = (ADDR_W + 1)'(6);
    localparam logic [ADDR_W:0] FCS_LEN  = (ADDR_W + 1)'(2);
    localparam logic [15:0]     CRC_INIT = 16'hFFFF;
    localparam logic [15:0]     CRC_GOOD = 16'hF0B8;

    localparam logic [1:0] ERR_CRC     = 2'd0;
    localparam logic [1:0] ERR_RUNT    = 2'd1;
    localparam logic [1:0] ERR_LONG    = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    state_t            state;
    logic              strobe_q;
    logic              end_q;
    logic [ADDR_W:0]   wr_cnt;
    logic [15:0]       crc;
    logic              lock_drop;
    logic [7:0]        mem [DEPTH];

    logic              byte_evt;
    logic              end_evt;
    logic              wr_en;
    logic              hdr_ok0;
    logic              hdr_ok1;

    // One CRC-16/CCITT byte step, LSB first, reflected polynomial.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    // Rising-edge events, header match and buffer write enable.
    always_comb begin
        byte_evt = data_strobe & ~strobe_q;
        end_evt  = frame_end & ~end_q;
        hdr_ok0  = promisc | (data_in == station_id) | (data_in == 8'hFF);
        hdr_ok1  = promisc | (data_in == 8'h00) | (data_in == net_id) | (data_in == 8'hFF);
        // frame_start and end events outrank a coincident byte; a full buffer takes no write.
        wr_en    = (state == RECV) & ~frame_start & ~end_evt & byte_evt & ~wr_cnt[ADDR_W];
    end

    assign fsm_state = state;

    // Frame buffer write port; contents are not reset.
    always_ff @(posedge econet_clk) begin
        if (wr_en) begin
            mem[wr_cnt[ADDR_W-1:0]] <= data_in;
        end
    end

    // Registered host read port.
    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    // Receive FSM, edge registers, CRC, buffer ownership and error reporting.
    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            strobe_q    <= 1'b0;
            end_q       <= 1'b0;
            wr_cnt      <= '0;
            crc         <= CRC_INIT;
            lock_drop   <= 1'b0;
            frame_ready <= 1'b0;
            frame_len   <= '0;
            err_strobe  <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            strobe_q   <= data_strobe;
            end_q      <= frame_end;
            err_strobe <= 1'b0;

            if (frame_ready && frame_ack) begin
                frame_ready <= 1'b0;
            end

            if (frame_start) begin
                // Lock decision uses the pre-edge frame_ready, so an ack on the
                // same edge still loses this frame as an overrun.
                if (frame_ready) begin
                    state     <= DISCARD;
                    lock_drop <= 1'b1;
                end else begin
                    state     <= RECV;
                    wr_cnt    <= '0;
                    crc       <= CRC_INIT;
                    lock_drop <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RECV: begin
                        if (end_evt) begin
                            state <= IDLE;
                            if (wr_cnt < MIN_CNT) begin
                                err_strobe <= 1'b1;
                                err_code   <= ERR_RUNT;
                            end else if (crc != CRC_GOOD) begin
                                err_strobe <= 1'b1;
                                err_code   <= ERR_CRC;
                            end else begin
                                frame_ready <= 1'b1;
                                frame_len   <= wr_cnt - FCS_LEN;
                            end
                        end else if (byte_evt) begin
                            if (wr_cnt[ADDR_W]) begin
                                err_strobe <= 1'b1;
                                err_code   <= ERR_LONG;
                                state      <= DISCARD;
                            end else begin
                                wr_cnt <= wr_cnt + 1'b1;
                                crc    <= crc_step(crc, data_in);
                                if ((wr_cnt == '0) && !hdr_ok0) begin
                                    state <= DISCARD;
                                end
                                if ((wr_cnt == (ADDR_W + 1)'(1)) && !hdr_ok1) begin
                                    state <= DISCARD;
                                end
                            end
                        end
                    end
                    DISCARD: begin
                        if (end_evt) begin
                            state <= IDLE;
                        end else if (byte_evt && lock_drop) begin
                            err_strobe <= 1'b1;
                            err_code   <= ERR_OVERRUN;
                            lock_drop  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_econet_rx_frame.sv
// tb_econet_rx_frame: directed bench for econet_rx_frame. A second
// instance with ADDR_W=4 shares all inputs for the too-long case.
module tb_econet_rx_frame;

    // Clock / reset
    logic       econet_clk = 1'b0;
    logic       reset;
    always #5 econet_clk = ~econet_clk;

    logic [7:0] data_in;
    logic       data_strobe;
    logic       frame_start;
    logic       frame_end;
    logic [7:0] station_id;
    logic [7:0] net_id;
    logic       promisc;
    logic [7:0] rd_addr;
    logic       frame_ack;

    logic       frame_ready;
    logic [8:0] frame_len;
    logic [7:0] rd_data;
    logic       err_strobe;
    logic [1:0] err_code;
    logic [1:0] fsm_state;

    logic       frame_ready2;
    logic [4:0] frame_len2;
    logic [7:0] rd_data2;
    logic       err_strobe2;
    logic [1:0] err_code2;
    logic [1:0] fsm_state2;

    econet_rx_frame #(.ADDR_W(8)) dut (
        .econet_clk(econet_clk), .reset(reset), .data_in(data_in),
        .data_strobe(data_strobe), .frame_start(frame_start), .frame_end(frame_end),
        .station_id(station_id), .net_id(net_id), .promisc(promisc),
        .frame_ready(frame_ready), .frame_len(frame_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_ack(frame_ack), .err_strobe(err_strobe),
        .err_code(err_code), .fsm_state(fsm_state)
    );

    econet_rx_frame #(.ADDR_W(4)) dut_small (
        .econet_clk(econet_clk), .reset(reset), .data_in(data_in),
        .data_strobe(data_strobe), .frame_start(frame_start), .frame_end(frame_end),
        .station_id(station_id), .net_id(net_id), .promisc(promisc),
        .frame_ready(frame_ready2), .frame_len(frame_len2), .rd_addr(rd_addr[3:0]),
        .rd_data(rd_data2), .frame_ack(frame_ack), .err_strobe(err_strobe2),
        .err_code(err_code2), .fsm_state(fsm_state2)
    );

    int checks = 0;
    int errors = 0;

    // Error-pulse scoreboard: counts of pulses seen per error code.
    int err_cnt  [4] = '{0, 0, 0, 0};
    int err_cnt2 [4] = '{0, 0, 0, 0};
    int base     [4];
    int base2    [4];

    always @(posedge econet_clk) begin
        #1;
        if (err_strobe)  err_cnt[err_code]   = err_cnt[err_code] + 1;
        if (err_strobe2) err_cnt2[err_code2] = err_cnt2[err_code2] + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            base[i]  = err_cnt[i];
            base2[i] = err_cnt2[i];
        end
    endtask

    function automatic int new_errs();
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += err_cnt[i] - base[i];
        return s;
    endfunction

    // Driver tasks: inputs change on the falling edge.
    task automatic pulse_start();
        @(negedge econet_clk); frame_start = 1'b1;
        @(negedge econet_clk); frame_start = 1'b0;
    endtask

    task automatic pulse_end();
        @(negedge econet_clk); frame_end = 1'b1;
        @(negedge econet_clk); frame_end = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge econet_clk);
        data_in     = b;
        data_strobe = 1'b1;
        repeat (hold) @(negedge econet_clk);
        data_strobe = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] payload[$], input int hold,
                              input logic bad_fcs, input logic do_start);
        logic [15:0] c;
        logic [7:0]  lo;
        c = 16'hFFFF;
        foreach (payload[i]) begin
            for (int k = 0; k < 8; k++) begin
                c = (c[0] ^ payload[i][k]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            end
        end
        c  = ~c;
        lo = c[7:0] ^ {7'b0, bad_fcs};
        if (do_start) pulse_start();
        foreach (payload[i]) send_byte(payload[i], hold);
        send_byte(lo, hold);
        send_byte(c[15:8], hold);
        pulse_end();
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        @(negedge econet_clk); rd_addr = addr;
        @(negedge econet_clk); check_eq(tag, rd_data, exp);
    endtask

    task automatic ack();
        @(negedge econet_clk); frame_ack = 1'b1;
        @(negedge econet_clk); frame_ack = 1'b0;
    endtask

    logic [7:0] frm_a[$];
    logic [7:0] frm_d[$];
    logic [7:0] frm_b[$];
    logic [7:0] frm_c[$];
    logic [7:0] frm_r[$];

    initial begin
        reset = 1'b1; data_in = 8'h00; data_strobe = 1'b0; frame_start = 1'b0;
        frame_end = 1'b0; station_id = 8'h05; net_id = 8'h01; promisc = 1'b0;
        rd_addr = 8'h00; frame_ack = 1'b0;
        frm_a = {8'h05, 8'h00, 8'hFE, 8'h00, 8'h99};
        frm_d = {8'h07, 8'h00, 8'hFE, 8'h00, 8'h99};
        frm_b = {8'h05, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        frm_c = {8'hFF, 8'hFF, 8'hAA, 8'hBB};
        frm_r = {8'h05, 8'h00, 8'h01};

        // Reset values
        repeat (3) @(negedge econet_clk);
        check_eq("rst_ready", frame_ready, 0);
        check_eq("rst_len", frame_len, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_err_strobe", err_strobe, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_state", fsm_state, 0);
        reset = 1'b0;
        repeat (2) @(negedge econet_clk);

        // Good frame for our station
        snap();
        send_frame(frm_a, 1, 1'b0, 1'b1);
        check_eq("a_ready", frame_ready, 1);
        check_eq("a_len", frame_len, 5);
        check_eq("a_no_err", new_errs(), 0);
        for (int i = 0; i < 5; i++) read_check($sformatf("a_rd%0d", i), 8'(i), frm_a[i]);
        ack();
        check_eq("a_ack_ready", frame_ready, 0);

        // FCS bit 0 flipped
        snap();
        send_frame(frm_a, 1, 1'b1, 1'b1);
        check_eq("crc_strobe", err_strobe, 1);
        check_eq("crc_code", err_code, 0);
        check_eq("crc_ready", frame_ready, 0);
        @(negedge econet_clk);
        check_eq("crc_strobe_1cyc", err_strobe, 0);
        check_eq("crc_pulses", err_cnt[0] - base[0], 1);

        // Foreign destination, then promiscuous
        snap();
        send_frame(frm_d, 1, 1'b0, 1'b1);
        repeat (2) @(negedge econet_clk);
        check_eq("dst_ready", frame_ready, 0);
        check_eq("dst_no_err", new_errs(), 0);
        promisc = 1'b1;
        send_frame(frm_d, 1, 1'b0, 1'b1);
        check_eq("prm_ready", frame_ready, 1);
        check_eq("prm_len", frame_len, 5);
        promisc = 1'b0;

        // Second frame while buffer is held: one overrun, contents kept
        snap();
        send_frame(frm_b, 1, 1'b0, 1'b1);
        check_eq("ovr_pulses", err_cnt[3] - base[3], 1);
        check_eq("ovr_total", new_errs(), 1);
        check_eq("ovr_code", err_code, 3);
        check_eq("ovr_ready", frame_ready, 1);
        check_eq("ovr_len", frame_len, 5);
        read_check("ovr_rd0", 8'd0, 8'h07);
        read_check("ovr_rd4", 8'd4, 8'h99);
        ack();
        send_frame(frm_c, 1, 1'b0, 1'b1);
        check_eq("c_ready", frame_ready, 1);
        check_eq("c_len", frame_len, 4);
        read_check("c_rd2", 8'd2, 8'hAA);
        read_check("c_rd3", 8'd3, 8'hBB);

        // Ack on the same edge as frame_start: frame still lost as overrun
        snap();
        @(negedge econet_clk); frame_ack = 1'b1; frame_start = 1'b1;
        @(negedge econet_clk); frame_ack = 1'b0; frame_start = 1'b0;
        check_eq("ackst_ready", frame_ready, 0);
        check_eq("ackst_state", fsm_state, 2);
        send_frame(frm_a, 1, 1'b0, 1'b0);
        check_eq("ackst_ovr", err_cnt[3] - base[3], 1);
        check_eq("ackst_ready2", frame_ready, 0);

        // Runt
        snap();
        pulse_start();
        foreach (frm_r[i]) send_byte(frm_r[i], 1);
        pulse_end();
        check_eq("runt_strobe", err_strobe, 1);
        check_eq("runt_code", err_code, 1);
        check_eq("runt_ready", frame_ready, 0);

        // Too long on the 16-byte instance: error on byte 17, end ignored
        snap();
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            send_byte((i == 0) ? 8'h05 : ((i == 1) ? 8'h00 : 8'(i)), 1);
            if (i == 15) check_eq("long_none_b16", err_cnt2[2] - base2[2], 0);
        end
        check_eq("long_pulse", err_cnt2[2] - base2[2], 1);
        check_eq("long_code", err_code2, 2);
        snap();
        pulse_end();
        @(negedge econet_clk);
        check_eq("long_end_ignored", err_cnt2[0] + err_cnt2[1] + err_cnt2[2] + err_cnt2[3]
                 - base2[0] - base2[1] - base2[2] - base2[3], 0);
        check_eq("long_ready2", frame_ready2, 0);

        // Repeated frame_start and 3-cycle strobes
        snap();
        repeat (3) pulse_start();
        send_frame(frm_a, 3, 1'b0, 1'b0);
        check_eq("hold_ready", frame_ready, 1);
        check_eq("hold_len", frame_len, 5);
        check_eq("hold_no_err", new_errs(), 0);
        read_check("hold_rd1", 8'd1, 8'h00);
        read_check("hold_rd2", 8'd2, 8'hFE);

        // Reset while frame_ready
        @(negedge econet_clk); reset = 1'b1;
        @(negedge econet_clk);
        check_eq("rstrdy_ready", frame_ready, 0);
        check_eq("rstrdy_len", frame_len, 0);
        reset = 1'b0;

        // Reset mid-frame, then clean restart
        pulse_start();
        foreach (frm_r[i]) send_byte(frm_r[i], 1);
        check_eq("mid_state", fsm_state, 1);
        @(negedge econet_clk); reset = 1'b1;
        @(negedge econet_clk);
        check_eq("mid_state_rst", fsm_state, 0);
        check_eq("mid_ready", frame_ready, 0);
        check_eq("mid_rd_data", rd_data, 0);
        check_eq("mid_err_code", err_code, 0);
        check_eq("mid_err_strobe", err_strobe, 0);
        reset = 1'b0;
        snap();
        send_frame(frm_a, 1, 1'b0, 1'b1);
        check_eq("post_ready", frame_ready, 1);
        check_eq("post_len", frame_len, 5);
        check_eq("post_no_err", new_errs(), 0);
        read_check("post_rd4", 8'd4, 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/econet_rx_frame.md
# econet_rx_frame

Frame-level receiver directly downstream of the Econet RX PHY: consumes its byte strobes and flag indications, filters on destination station/network, checks the HDLC FCS (CRC-16/CCITT), and stores one accepted frame in a local byte buffer. The host side reads the buffer through a random-access port and releases it with an acknowledge. Single clock domain (econet_clk); any host-side CDC lives outside this block.

## Interface
- ADDR_W, 8, buffer address width; buffer holds 2**ADDR_W bytes including the 2 FCS bytes
- reset  in  1  asynchronous, active-high
- econet_clk  in  1  Econet clock; all logic on posedge
- data_in  in  8  received byte from PHY; first bit on the wire is bit 0
- data_strobe  in  1  PHY byte strobe, level; may stay high >1 cycle
- frame_start  in  1  PHY opening flag seen
- frame_end  in  1  PHY closing flag seen
- station_id  in  8  our station number
- net_id  in  8  our network number
- promisc  in  1  1 = accept every destination
- frame_ready  out  1  buffer holds a valid, CRC-checked frame
- frame_len  out  ADDR_W+1  payload length, FCS excluded; valid while frame_ready
- rd_addr  in  ADDR_W  host read address
- rd_data  out  8  buffer byte at rd_addr, 1-cycle registered latency
- frame_ack  in  1  host releases buffer; sampled only while frame_ready
- err_strobe  out  1  one-cycle error pulse
- err_code  out  2  0 CRC, 1 runt, 2 too long, 3 overrun; held until next err_strobe

## Operation
- Edge detection: byte event = data_strobe high and registered copy low; end event = frame_end high and registered copy low. frame_start acted on at every cycle it is high.
- FSM states: IDLE, RECV, DISCARD.
- IDLE/RECV/DISCARD + frame_start: if frame_ready then DISCARD with lock_drop=1; else RECV, wr_cnt=0, crc=0xFFFF, lock_drop=0. Restart on frame_start covers aborts and back-to-back flags.
- RECV + byte event: write data_in at buffer[wr_cnt], wr_cnt+1, crc updated bitwise LSB first, reflected poly 0x8408.
  - wr_cnt==0: byte must equal station_id or 0xFF (or promisc) else DISCARD, no error.
  - wr_cnt==1: byte must equal 0x00, net_id or 0xFF (or promisc) else DISCARD, no error.
  - wr_cnt==2**ADDR_W at byte event: err too long, DISCARD.
- RECV + end event: wr_cnt<6 (4 header + 2 FCS) -> err runt; else crc!=0xF0B8 -> err CRC; else frame_ready=1, frame_len=wr_cnt-2. Then IDLE.
- DISCARD + byte event with lock_drop=1: err overrun once per frame (clear lock_drop). DISCARD + end event -> IDLE.
- IDLE ignores byte and end events.
- frame_ready + frame_ack -> frame_ready=0 next edge; buffer free for the next frame_start.
- rd_data always reads the buffer; content defined only while frame_ready.

## Timing
- Reset values: frame_ready 0, frame_len 0, rd_data 0, err_strobe 0, err_code 0, FSM IDLE, edge registers 0, crc 0xFFFF, wr_cnt 0.
- Byte written on the same posedge the byte event is sampled.
- frame_ready rises (or err_strobe pulses) on the posedge the end event is sampled: zero extra latency.
- rd_data valid one posedge after rd_addr.
- frame_ack at same edge as a frame_start: ack wins first; that frame_start sees frame_ready=1 and is discarded as overrun (lock evaluated on pre-edge value).
- Reset mid-frame or while frame_ready: all state to reset values at once, buffer released; contents need not be cleared.

## Test plan
- Frame 0x05,0x00,0xFE,0x00,0x99 + correct FCS (bench CRC model, complemented, low byte first), station_id=0x05 -> frame_ready=1, frame_len=5, rd_addr 0..4 return those bytes next cycle.
- Same frame with FCS bit 0 flipped -> err_strobe one cycle, err_code=0, frame_ready stays 0.
- Destination 0x07, station_id=0x05, promisc=0 -> no frame_ready, no err_strobe; promisc=1 -> accepted, frame_len=5.
- Second valid frame while frame_ready=1 -> err_code=3 once, first frame contents unchanged; after frame_ack, third frame accepted.
- 3 bytes then frame_end -> err_code=1; ADDR_W=4, 17 bytes -> err_code=2 on byte 17, later frame_end ignored.
- data_strobe held high 3 cycles per byte, frame_start repeated 3 times before data, reset asserted mid-frame -> each byte stored once, frame restarts cleanly, all outputs 0 after reset.
